icache: RTL
===========

# icache

Direct-mapped, read-only instruction cache sitting between the CPU fetch port and the instruction memory. It is the fetch-side counterpart of `dcache`. The CPU presents `PC` and receives `INSTRUCTION` with a `BUSYWAIT` stall. On a miss the cache reads one 16-byte block from instruction memory over a `mem_read`/`mem_busywait` handshake. The handshake is of the same style as `data_memory`.

## Interface
- `ADDR_W`, default 10: PC bits used, giving a 1024-byte instruction space. `PC[31:ADDR_W]` is ignored.
- `INDEX_W`, default 3: number of index bits, giving 8 lines. Tag width = `ADDR_W-INDEX_W-4`, which is 3 at the defaults.

Ports:
- `CLK` in 1: clock, rising edge.
- `RESET` in 1: synchronous, active-high.
- `PC` in 32: CPU fetch byte address. Word-aligned; `PC[1:0]` is ignored.
- `INSTRUCTION` out 32: fetched word.
- `BUSYWAIT` out 1: CPU must hold `PC` and stall while this is high.
- `mem_read` out 1: block read request to instruction memory.
- `mem_address` out `ADDR_W-4`: block address, equal to `PC[ADDR_W-1:4]`.
- `mem_readdata` in 128: block data. Word k is bits `[32k+31:32k]`.
- `mem_busywait` in 1: memory busy. It rises combinationally with `mem_read` and falls when `mem_readdata` is valid.

## Operation
- Storage: 8 lines, each holding a valid bit, a tag, and 128 data bits.
- Address split on `PC[ADDR_W-1:0]`:
  - tag = `[ADDR_W-1:ADDR_W-3]`
  - index = `[6:4]`
  - word = `[3:2]`
- Hit is combinational: `valid[index] && tag[index]==PC tag`.
- `INSTRUCTION` = selected word of `data[index]`, driven combinationally in every state.
- FSM states:
  - IDLE:
    - `BUSYWAIT` = !hit.
    - On a miss, at the next edge, latch `req_addr = PC[ADDR_W-1:4]` and go to MEM_READ.
  - MEM_READ:
    - `mem_read`=1, `mem_address`=`req_addr`, `BUSYWAIT`=1.
    - At an edge with `mem_busywait`=0, capture `mem_readdata` into `line_buf` and go to FILL.
    - Otherwise stay in MEM_READ.
  - FILL:
    - `mem_read`=0, `BUSYWAIT`=1.
    - At the edge, write `line_buf`, the tag from `req_addr`, and valid=1 into line `req_addr[INDEX_W-1:0]`.
    - Go to IDLE.
- Replacement: the new block unconditionally overwrites its line. The cache is read-only, so no writeback.
- In MEM_READ and FILL, `PC` is ignored. Fill uses `req_addr`. IDLE re-evaluates whatever `PC` is current.

## Timing
- Hit: zero-cycle latency, `BUSYWAIT`=0 in the same cycle `PC` is presented.
- Miss with memory busy for N cycles:
  - `BUSYWAIT` is high for 1 (IDLE) + N+1 (MEM_READ) + 1 (FILL) cycles.
  - After FILL, `PC` hits.
- `mem_read` is high only in MEM_READ and drops for at least one cycle between consecutive block requests.
- RESET sampled high at an edge:
  - All valid bits clear, state goes to IDLE, `line_buf` and `req_addr` clear.
- Output values while in reset:
  - While `RESET` is high, `BUSYWAIT`=0 and `INSTRUCTION`=0.
  - After the reset edge, `mem_read`=0.
- Reset in MEM_READ or FILL: the request is abandoned, `mem_read` is low after the reset edge, and no line is written.
- A miss after reset always refetches.

## Configuration
- `ICACHE_PERF_EN`:
  - When defined, two output ports are added: `hit_count` out 16 and `miss_count` out 16.
  - Both are saturating at 0xFFFF and cleared by `RESET`.
  - `hit_count` increments at each edge in IDLE with hit and `RESET`=0.
  - `miss_count` increments at each IDLE→MEM_READ transition.
- When undefined, the ports and counters are absent; the functional behaviour is identical.

## Structure
- Package `icache_pkg` holds:
  - the state enum (IDLE, MEM_READ, FILL)
  - `LINE_W`=128, `OFFSET_W`=4, `WORD_W`=32
  - the tag/index/word extraction helpers
- One sub-module, `icache_line_array`: valid/tag/data storage with a combinational read port (index → valid, tag, data), a one-line synchronous write port, and synchronous clear of valid.
- The FSM, hit compare and word mux live in `icache`.

## Test plan
- Cold miss: RESET, then `PC`=0x000 with a memory busy for 5 cycles and block {w3..w0}={0x..03,0x..02,0x..01,0x..00} → `BUSYWAIT` high for 8 cycles, `mem_read` with `mem_address`=0 for 6 cycles, then `INSTRUCTION`=w0 and `BUSYWAIT`=0.
- Hits: after the above, `PC`=0x004, 0x008, 0x00C on consecutive cycles → `INSTRUCTION`=w1, w2, w3, `BUSYWAIT`=0, `mem_read` never asserted.
- Conflict: `PC`=0x080 (index 0, tag 1) → miss with `mem_address`=0x08, line 0 replaced. Then `PC`=0x000 → miss again with `mem_address`=0x00.
- Alias: after filling block 0, `PC`=0x400 → hit, `INSTRUCTION`=w0, because bit 10 is ignored.
- Reset mid-fill: assert `RESET` in cycle 3 of MEM_READ → `mem_read`=0 after that edge, no line written. After release, `PC`=0 → miss.
- With `ICACHE_PERF_EN`: 1 miss followed by 3 hits → `miss_count`=1 and `hit_count`=3. Forcing hits past 65535 → `hit_count` holds 0xFFFF.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache.
// Holds the controller state encoding, the line geometry constants and the
// address-field extraction helpers used by icache and icache_line_array.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        FILL     = 2'd2
    } state_e;

    localparam int LINE_W   = 128;
    localparam int OFFSET_W = 4;
    localparam int WORD_W   = 32;

    // Tag portion of a block address (block address = byte address >> OFFSET_W).
    function automatic logic [31:0] tagOf(input logic [31:0] blk, input int indexW);
        return blk >> indexW;
    endfunction

    // Index portion of a block address.
    function automatic logic [31:0] indexOf(input logic [31:0] blk, input int indexW);
        return blk & ((32'd1 << indexW) - 32'd1);
    endfunction

    // Word-within-block selector taken from the byte offset.
    function automatic logic [1:0] wordSel(input logic [OFFSET_W-1:0] offset);
        return offset[3:2];
    endfunction

    // Pick one 32-bit word out of a 128-bit line; word k lives at [32k+31:32k].
    function automatic logic [WORD_W-1:0] wordOf(input logic [LINE_W-1:0] line,
                                                 input logic [1:0] sel);
        return line[sel*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache.
// Combinational read port addressed by index, one-line synchronous write
// port, and a synchronous clear of every valid bit on reset.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [INDEX_W-1:0] rdIndex_i,
    output logic               rdValid_o,
    output logic [TAG_W-1:0]   rdTag_o,
    output logic [LINE_W-1:0]  rdData_o,
    input  logic               wrEn_i,
    input  logic [INDEX_W-1:0] wrIndex_i,
    input  logic [TAG_W-1:0]   wrTag_i,
    input  logic [LINE_W-1:0]  wrData_i
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    // Valid bits: cleared by reset (which also wins over a pending fill), set by a fill.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
        end else if (wrEn_i) begin
            valid_q[wrIndex_i] <= 1'b1;
        end
    end

    // Tag and data payload; only meaningful once the valid bit is set, so no reset.
    always_ff @(posedge clk_i) begin
        if (wrEn_i && !reset_i) begin
            tag_q[wrIndex_i]  <= wrTag_i;
            data_q[wrIndex_i] <= wrData_i;
        end
    end

    assign rdValid_o = valid_q[rdIndex_i];
    assign rdTag_o   = tag_q[rdIndex_i];
    assign rdData_o  = data_q[rdIndex_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between CPU fetch and instruction memory.
// Hits return in the same cycle; a miss fetches one 16-byte block through
// IDLE -> MEM_READ -> FILL. Defining ICACHE_PERF_EN adds saturating
// hit_count/miss_count outputs.
module icache
    import icache_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int INDEX_W = 3
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [31:0]                PC,
    output logic [31:0]                INSTRUCTION,
    output logic                       BUSYWAIT,
    output logic                       mem_read,
    output logic [ADDR_W-OFFSET_W-1:0] mem_address,
    input  logic [LINE_W-1:0]          mem_readdata,
    input  logic                       mem_busywait
`ifdef ICACHE_PERF_EN
    ,
    output logic [15:0]                hit_count,
    output logic [15:0]                miss_count
`endif
);

    localparam int BLK_W = ADDR_W - OFFSET_W;
    localparam int TAG_W = BLK_W - INDEX_W;

    state_e              state_q, state_d;
    logic [BLK_W-1:0]    reqAddr_q, reqAddr_d;
    logic [LINE_W-1:0]   lineBuf_q, lineBuf_d;

    logic [BLK_W-1:0]    pcBlk;
    logic [INDEX_W-1:0]  pcIndex;
    logic [TAG_W-1:0]    pcTag;
    logic                lineValid;
    logic [TAG_W-1:0]    lineTag;
    logic [LINE_W-1:0]   lineData;
    logic                hit;
    logic                busy;
    logic                fillEn;

    assign pcBlk   = PC[ADDR_W-1:OFFSET_W];
    assign pcIndex = INDEX_W'(indexOf(32'(pcBlk), INDEX_W));
    assign pcTag   = TAG_W'(tagOf(32'(pcBlk), INDEX_W));

    icache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_lines (
        .clk_i     (CLK),
        .reset_i   (RESET),
        .rdIndex_i (pcIndex),
        .rdValid_o (lineValid),
        .rdTag_o   (lineTag),
        .rdData_o  (lineData),
        .wrEn_i    (fillEn),
        .wrIndex_i (INDEX_W'(indexOf(32'(reqAddr_q), INDEX_W))),
        .wrTag_i   (TAG_W'(tagOf(32'(reqAddr_q), INDEX_W))),
        .wrData_i  (lineBuf_q)
    );

    assign hit = lineValid && (lineTag == pcTag);

    // Controller next-state and outputs; PC only matters while IDLE.
    always_comb begin
        state_d   = state_q;
        reqAddr_d = reqAddr_q;
        lineBuf_d = lineBuf_q;
        busy      = 1'b0;
        mem_read  = 1'b0;
        fillEn    = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = !hit;
                if (!hit) begin
                    reqAddr_d = pcBlk;
                    state_d   = MEM_READ;
                end
            end
            MEM_READ: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    lineBuf_d = mem_readdata;
                    state_d   = FILL;
                end
            end
            FILL: begin
                busy    = 1'b1;
                fillEn  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers; reset abandons any in-flight request.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            reqAddr_q <= '0;
            lineBuf_q <= '0;
        end else begin
            state_q   <= state_d;
            reqAddr_q <= reqAddr_d;
            lineBuf_q <= lineBuf_d;
        end
    end

    assign mem_address = reqAddr_q;
    assign BUSYWAIT    = RESET ? 1'b0 : busy;
    assign INSTRUCTION = RESET ? '0 : wordOf(lineData, wordSel(PC[OFFSET_W-1:0]));

`ifdef ICACHE_PERF_EN
    logic [15:0] hitCount_q, hitCount_d;
    logic [15:0] missCount_q, missCount_d;

    // Saturating event counters for IDLE hits and IDLE->MEM_READ transitions.
    always_comb begin
        hitCount_d  = hitCount_q;
        missCount_d = missCount_q;
        if (state_q == IDLE && hit && hitCount_q != 16'hFFFF) begin
            hitCount_d = hitCount_q + 16'd1;
        end
        if (state_q == IDLE && !hit && missCount_q != 16'hFFFF) begin
            missCount_d = missCount_q + 16'd1;
        end
    end

    // Counter registers, cleared together with the rest of the cache.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hitCount_q  <= '0;
            missCount_q <= '0;
        end else begin
            hitCount_q  <= hitCount_d;
            missCount_q <= missCount_d;
        end
    end

    assign hit_count  = hitCount_q;
    assign miss_count = missCount_q;
`endif

endmodule
